exec_sequencer: RTL
===================

Name: exec_sequencer

Overview:
Run-control sequencer for the pipelined CPU. It decides when the fetch stage and the downstream pipeline registers advance. It supports continuous run and single-step modes, and drains the pipeline after a HALT instruction is fetched. It drives the enable, start and not-load controls of the program-counter stage and exposes status and a cycle counter to the debug/UART unit.

Parameters:
CYCLE_W, 32, width of the executed-cycle counter
DRAIN_TIMEOUT, 16, max enabled cycles between HALT fetch and HALT writeback before error

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_run  in  1  debug command: continuous execution (1-cycle pulse)
i_step  in  1  debug command: advance pipeline one cycle (1-cycle pulse)
i_abort  in  1  debug command: stop immediately, return to idle
i_clear  in  1  acknowledge completion, return to idle
i_halt_fetched  in  1  HALT opcode present in IF this cycle
i_halt_wb  in  1  HALT instruction reached WB this cycle
i_load_use_hazard  in  1  hazard unit request to hold PC and IF/ID
o_pipe_enable  out  1  global advance enable for PC and pipeline registers
o_pc_start  out  1  start strobe to PC stage
o_pc_not_load  out  1  hold PC this cycle
o_busy  out  1  program in progress (any state except IDLE/DONE)
o_done  out  1  program finished
o_error  out  1  drain timeout occurred (valid with o_done)
o_state  out  3  current state encoding
o_cycle_count  out  CYCLE_W  enabled cycles since last start

Behaviour:
- One clock domain. All state and counters update on posedge i_clk; i_reset has priority over everything.
- Reset values: state=IDLE, o_cycle_count=0, o_error=0, started flag=0; every output 0.
- States and encoding:
  - IDLE=0, RUN=1, STEP_WAIT=2, STEP_EXEC=3, DRAIN=4, DONE=5. Codes 6-7 are illegal and go to IDLE next cycle.
- Per-state enable (o_pipe_enable, combinational from state):
  - 1 in RUN, STEP_EXEC, DRAIN.
  - 0 in IDLE, STEP_WAIT, DONE.
- o_pc_start = o_pipe_enable & ~started.
  - started sets at the end of the first enabled cycle and clears in IDLE.
  - Net effect: start is high for exactly one cycle per program, coincident with the first enable.
- o_pc_not_load = o_pipe_enable & i_load_use_hazard (combinational, zero latency).
- o_cycle_count increments by 1 at each clock edge where o_pipe_enable=1. It saturates at all-ones and clears on the IDLE->RUN/STEP_WAIT transition.
- Transitions:
  - IDLE: i_run -> RUN. Else i_step -> STEP_WAIT. If both are asserted, run wins. The step pulse used to leave IDLE does not itself execute a cycle.
  - RUN: i_halt_fetched -> DRAIN (the HALT-fetch cycle itself is enabled). Otherwise stay. i_run/i_step are ignored.
  - STEP_WAIT: i_run -> RUN. Else i_step -> STEP_EXEC.
  - STEP_EXEC: exactly one enabled cycle.
    - i_halt_wb -> DONE.
    - Else if i_halt_fetched or halt_seen -> STEP_WAIT with halt_seen=1.
    - Else -> STEP_WAIT.
    - In step mode, DONE is reached only when i_halt_wb=1 during a STEP_EXEC cycle.
  - DRAIN: the drain counter counts enabled cycles. i_halt_wb -> DONE. If the counter reaches DRAIN_TIMEOUT first -> DONE with o_error=1. If both happen in the same cycle, normal completion wins (o_error=0).
  - DONE: hold o_done=1, o_cycle_count frozen. i_clear -> IDLE, which clears o_error and halt_seen.
- i_abort in any non-IDLE state -> IDLE next cycle. The abort cycle's enable still follows the current state. Abort has priority over all other commands; i_clear is ignored outside DONE.
- i_halt_wb arriving in RUN (HALT already past fetch without a halt_fetched strobe) -> DONE directly.
- Hazard during the HALT-fetch cycle: the transition to DRAIN still occurs, and not_load is still asserted that cycle.

Test Plan:
- Reset mid-RUN with o_cycle_count=7 -> next cycle state=0, all outputs 0, count=0.
- IDLE, i_run pulse -> RUN; o_pc_start=1 only in the first RUN cycle. Halt_fetched at count 10, halt_wb 4 cycles later -> DONE, o_cycle_count=15, o_error=0.
- IDLE, step pulse, then 3 step pulses separated by idle cycles -> exactly 3 enabled cycles, o_cycle_count=3, o_pc_start high only with the first. Then a run pulse in STEP_WAIT -> RUN.
- RUN with i_load_use_hazard held for 2 cycles -> o_pc_not_load=1 for those 2 cycles; count keeps incrementing.
- DRAIN with no i_halt_wb -> DONE after 16 enabled drain cycles, o_error=1. Then i_clear -> IDLE, o_error=0.
- i_abort during DRAIN, and again during STEP_WAIT -> IDLE next cycle, o_busy=0, o_done=0. Simultaneous i_run+i_step in IDLE -> RUN.

Source files
------------

// File: rtl/exec_sequencer.sv
// exec_sequencer: run-control sequencer for the PC stage and pipeline registers
//   i_clk, i_reset                  : clock, synchronous active-high reset
//   i_run, i_step, i_abort, i_clear : debug run-control commands
//   i_halt_fetched, i_halt_wb       : HALT seen in IF / reaching WB
//   i_load_use_hazard               : hazard unit hold request
//   o_pipe_enable, o_pc_start, o_pc_not_load : pipeline and PC controls
//   o_busy, o_done, o_error, o_state, o_cycle_count : debug status
module exec_sequencer #(
  parameter int CYCLE_W       = 32,
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_run,
  input  logic               i_step,
  input  logic               i_abort,
  input  logic               i_clear,
  input  logic               i_halt_fetched,
  input  logic               i_halt_wb,
  input  logic               i_load_use_hazard,
  output logic               o_pipe_enable,
  output logic               o_pc_start,
  output logic               o_pc_not_load,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error,
  output logic [2:0]         o_state,
  output logic [CYCLE_W-1:0] o_cycle_count
);
  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    STEP_WAIT = 3'd2,
    STEP_EXEC = 3'd3,
    DRAIN     = 3'd4,
    DONE      = 3'd5
  } state_t;
  state_t             state_q, state_d;
  logic               started_q, started_d;
  logic               halt_seen_q, halt_seen_d;
  logic               error_q, error_d;
  logic [CYCLE_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic               en, timeout;
  always_comb begin
    en          = state_q inside {RUN, STEP_EXEC, DRAIN};
    // drain_q counts completed drain cycles, so this is the last allowed one
    timeout     = drain_q == DW'(DRAIN_TIMEOUT - 1);
    state_d     = state_q;
    halt_seen_d = halt_seen_q;
    error_d     = error_q;
    case (state_q)
      IDLE:      state_d = i_run ? RUN : i_step ? STEP_WAIT : IDLE;
      RUN:       state_d = i_halt_wb ? DONE : i_halt_fetched ? DRAIN : RUN;
      STEP_WAIT: state_d = i_run ? RUN : i_step ? STEP_EXEC : STEP_WAIT;
      STEP_EXEC: begin
        state_d     = i_halt_wb ? DONE : STEP_WAIT;
        halt_seen_d = halt_seen_q | i_halt_fetched;
      end
      DRAIN: begin
        state_d = (i_halt_wb || timeout) ? DONE : DRAIN;
        error_d = ~i_halt_wb & timeout;
      end
      DONE:      state_d = i_clear ? IDLE : DONE;
      default:   state_d = IDLE;
    endcase
    if (i_abort && state_q != IDLE) state_d = IDLE;
    if (state_d == IDLE) begin
      halt_seen_d = 1'b0;
      error_d     = 1'b0;
    end
    started_d = (state_q == IDLE) ? 1'b0 : started_q | en;
    drain_d   = (state_q == DRAIN && state_d == DRAIN) ? drain_q + DW'(1) : '0;
    // count survives in IDLE for the debugger; cleared only when a program starts
    cnt_d     = (state_q == IDLE && state_d != IDLE) ? '0 :
                (en && !(&cnt_q)) ? cnt_q + CYCLE_W'(1) : cnt_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      started_q   <= 1'b0;
      halt_seen_q <= 1'b0;
      error_q     <= 1'b0;
      cnt_q       <= '0;
      drain_q     <= '0;
    end else begin
      state_q     <= state_d;
      started_q   <= started_d;
      halt_seen_q <= halt_seen_d;
      error_q     <= error_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
    end
  end
  assign o_pipe_enable = en;
  assign o_pc_start    = en & ~started_q;
  assign o_pc_not_load = en & i_load_use_hazard;
  assign o_busy        = !(state_q inside {IDLE, DONE});
  assign o_done        = state_q == DONE;
  assign o_error       = error_q;
  assign o_state       = state_q;
  assign o_cycle_count = cnt_q;
endmodule
